// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, data width and parity helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write handshake into the UART transmitter (valid/ready, no pass-through).
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic                      wr_valid;
  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      wr_ready;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; full blocks pushes even on a same-edge pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1 / 8E1, LSB first) fed from a small byte FIFO.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_EN  = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  uart_tx_fifo_if.slave                     wr,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state;
  logic [CNT_W-1:0]          cnt;
  logic [BIT_W-1:0]          bit_idx;
  logic [BIT_W-1:0]          next_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      bit_end;
  logic                      pop;

  assign bit_end     = (cnt == CNT_LAST);
  assign next_idx    = bit_idx + BIT_W'(1);
  assign wr.wr_ready = !fifo_full;
  // Pop from IDLE, or at the end of STOP so the next START follows with no gap.
  assign pop = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && bit_end));

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr.wr_valid),
    .pop     (pop),
    .wr_data (wr.wr_data),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      cnt <= bit_end ? '0 : cnt + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pop) begin
            shreg   <= fifo_rd_data;
            bit_idx <= '0;
            state   <= ST_START;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            tx    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                tx    <= even_parity(shreg);
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= next_idx;
              tx      <= shreg[next_idx];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shreg   <= fifo_rd_data;
              bit_idx <= '0;
              state   <= ST_START;
              tx      <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: two transmitters (8N1 and 8E1) checked against a frame-level line model.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if if0 ();
  uart_tx_fifo_if if1 ();

  logic       tx0, tx1, busy0, busy1;
  logic [2:0] fc0, fc1;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .wr(if0), .tx(tx0), .busy(busy0), .fifo_count(fc0)
  );

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .wr(if1), .tx(tx1), .busy(busy1), .fifo_count(fc1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit saw_block;
  logic [7:0] sent[$];
  logic [7:0] rcvd[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic get_tx(int s);       return (s == 0) ? tx0 : tx1;             endfunction
  function automatic logic get_busy(int s);     return (s == 0) ? busy0 : busy1;         endfunction
  function automatic logic get_ready(int s);    return (s == 0) ? if0.wr_ready : if1.wr_ready; endfunction
  function automatic logic [2:0] get_count(int s); return (s == 0) ? fc0 : fc1;          endfunction

  task automatic set_wr(int s, logic v, logic [7:0] d);
    if (s == 0) begin
      if0.wr_valid = v; if0.wr_data = d;
    end else begin
      if1.wr_valid = v; if1.wr_data = d;
    end
  endtask

  // Line level of bit slot idx of a frame: start, data LSB first, optional even parity, stop.
  function automatic logic model_bit(logic [7:0] b, int par, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return ((b >> (idx - 1)) & 8'd1) != 8'd0;
    if (par != 0 && idx == 9) return ($countones(b) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic send_and_capture(int s, logic [7:0] b, string tag);
    int   flen;
    int   k;
    bit   done;
    logic cap[$];
    flen = (10 + s) * CLK_DIV;
    @(negedge clk);
    set_wr(s, 1'b1, b);
    n_tests++;
    if (get_ready(s) !== 1'b1) begin n_fail++; $display("FAIL %s ready_before: got %b want 1", tag, get_ready(s)); end
    @(posedge clk); #1;
    set_wr(s, 1'b0, 8'h00);
    n_tests++;
    if (get_count(s) !== 3'd1) begin n_fail++; $display("FAIL %s count_after_push: got %0d want 1", tag, get_count(s)); end
    n_tests++;
    if (get_tx(s) !== 1'b1) begin n_fail++; $display("FAIL %s tx_before_start: got %b want 1", tag, get_tx(s)); end
    @(posedge clk); #1;
    n_tests++;
    if (get_tx(s) !== 1'b0) begin n_fail++; $display("FAIL %s tx_start_latency: got %b want 0", tag, get_tx(s)); end
    n_tests++;
    if (get_busy(s) !== 1'b1) begin n_fail++; $display("FAIL %s busy_at_start: got %b want 1", tag, get_busy(s)); end
    n_tests++;
    if (get_count(s) !== 3'd0) begin n_fail++; $display("FAIL %s count_after_pop: got %0d want 0", tag, get_count(s)); end
    k = 0;
    done = 0;
    while (!done && k < 500) begin
      @(negedge clk);
      if (get_busy(s) !== 1'b1) done = 1;
      else begin cap.push_back(get_tx(s)); k++; end
    end
    n_tests++;
    if (cap.size() != flen) begin n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, cap.size(), flen); end
    for (int i = 0; i < cap.size() && i < flen; i++) begin
      n_tests++;
      if (cap[i] !== model_bit(b, s, i / CLK_DIV)) begin
        n_fail++;
        $display("FAIL %s line_cycle_%0d: got %b want %b", tag, i, cap[i], model_bit(b, s, i / CLK_DIV));
      end
    end
  endtask

  task automatic drive_bytes(int n);
    logic [7:0] b;
    bit blocked;
    int w;
    saw_block = 0;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      @(negedge clk);
      if0.wr_valid = 1'b1;
      if0.wr_data  = b;
      blocked = 0;
      w = 0;
      while (if0.wr_ready !== 1'b1 && w < 1000) begin
        if (!blocked) begin
          blocked = 1;
          saw_block = 1;
          n_tests++;
          if (fc0 !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", fc0); end
        end
        @(negedge clk);
        w++;
      end
      n_tests++;
      if (w >= 1000) begin
        n_fail++;
        $display("FAIL ready_timeout: got wr_ready=%b want 1", if0.wr_ready);
        if0.wr_valid = 1'b0;
        return;
      end
      if (blocked) begin
        n_tests++;
        if (fc0 !== 3'd3) begin n_fail++; $display("FAIL pop_blocks_push: got count %0d want 3", fc0); end
      end
      @(posedge clk); #1;
      sent.push_back(b);
      if (blocked) begin
        n_tests++;
        if (fc0 !== 3'd4) begin n_fail++; $display("FAIL refill_count: got %0d want 4", fc0); end
      end
    end
    if0.wr_valid = 1'b0;
  endtask

  task automatic recv_frames(int n);
    int prev;
    int w;
    logic [7:0] d;
    prev = -1;
    for (int f = 0; f < n; f++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (tx0 !== 1'b0 && w < 2000);
      n_tests++;
      if (w >= 2000) begin n_fail++; $display("FAIL start_timeout: frame %0d got none want start", f); return; end
      if (prev >= 0) begin
        n_tests++;
        if (cyc - prev != 10 * CLK_DIV) begin
          n_fail++; $display("FAIL frame_gap: frame %0d got %0d cycles want %0d", f, cyc - prev, 10 * CLK_DIV);
        end
      end
      prev = cyc;
      repeat (2) @(negedge clk);
      n_tests++;
      if (tx0 !== 1'b0) begin n_fail++; $display("FAIL start_bit: frame %0d got %b want 0", f, tx0); end
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk);
        d[i] = tx0;
      end
      repeat (CLK_DIV) @(negedge clk);
      n_tests++;
      if (tx0 !== 1'b1) begin n_fail++; $display("FAIL stop_bit: frame %0d got %b want 1", f, tx0); end
      rcvd.push_back(d);
    end
  endtask

  task automatic run_stream(int n, string tag);
    int w;
    sent.delete();
    rcvd.delete();
    fork
      drive_bytes(n);
      recv_frames(n);
    join
    n_tests++;
    if (rcvd.size() != n) begin n_fail++; $display("FAIL %s rx_count: got %0d want %0d", tag, rcvd.size(), n); end
    for (int i = 0; i < rcvd.size() && i < sent.size(); i++) begin
      n_tests++;
      if (rcvd[i] !== sent[i]) begin n_fail++; $display("FAIL %s rx_byte_%0d: got %h want %h", tag, i, rcvd[i], sent[i]); end
    end
    w = 0;
    while (busy0 !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL %s idle_after: got busy %b want 0", tag, busy0); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_tests++;
      if (get_tx(s) !== 1'b1) begin n_fail++; $display("FAIL reset_tx%0d: got %b want 1", s, get_tx(s)); end
      n_tests++;
      if (get_busy(s) !== 1'b0) begin n_fail++; $display("FAIL reset_busy%0d: got %b want 0", s, get_busy(s)); end
      n_tests++;
      if (get_ready(s) !== 1'b1) begin n_fail++; $display("FAIL reset_ready%0d: got %b want 1", s, get_ready(s)); end
      n_tests++;
      if (get_count(s) !== 3'd0) begin n_fail++; $display("FAIL reset_count%0d: got %0d want 0", s, get_count(s)); end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got tx=%b busy=%b want tx=1 busy=0", tx0, busy0);
    end
  endtask

  task automatic test_single();
    send_and_capture(0, 8'hA5, "single_a5");
  endtask

  task automatic test_parity();
    send_and_capture(1, 8'h07, "parity_07");
    send_and_capture(1, 8'h03, "parity_03");
    for (int i = 0; i < 3; i++) send_and_capture(1, 8'($urandom_range(0, 255)), "parity_rand");
  endtask

  task automatic test_burst_full();
    run_stream(6, "burst6");
    n_tests++;
    if (saw_block !== 1'b1) begin n_fail++; $display("FAIL burst_ready_drop: got %b want 1", saw_block); end
  endtask

  task automatic test_wraparound();
    run_stream(10, "wrap10");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b1, b2, b3;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    b3 = 8'($urandom_range(0, 255));
    @(negedge clk); if0.wr_valid = 1'b1; if0.wr_data = b1;
    @(posedge clk);
    @(negedge clk); if0.wr_data = b2;
    @(posedge clk);
    @(negedge clk); if0.wr_data = b3;
    @(posedge clk);
    @(negedge clk); if0.wr_valid = 1'b0;
    // Now half a cycle after push edge N+2; data bit 3 spans edges N+17..N+21.
    repeat (16) @(negedge clk);
    n_tests++;
    if (tx0 !== b1[3]) begin n_fail++; $display("FAIL midframe_bit3: got %b want %b", tx0, b1[3]); end
    n_tests++;
    if (fc0 !== 3'd2) begin n_fail++; $display("FAIL midframe_count: got %0d want 2", fc0); end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (tx0 !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b want 1", tx0); end
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy0); end
    n_tests++;
    if (fc0 !== 3'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d want 0", fc0); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (fc0 !== 3'd0 || tx0 !== 1'b1 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL after_release: got count=%0d tx=%b busy=%b want 0/1/0", fc0, tx0, busy0);
    end
    send_and_capture(0, 8'h55, "post_reset_55");
  endtask

  initial begin
    set_wr(0, 1'b0, 8'h00);
    set_wr(1, 1'b0, 8'h00);
    test_reset();
    test_single();
    test_parity();
    test_burst_full();
    test_wraparound();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
